// File: rtl/filter_ctrl.sv
// Sequencer ahead of the multiply-add filter array. It loads one full kernel through the
// token-addressed config port, streams image columns, and drains in-flight results before any reload.
module filter_ctrl #(
    parameter int HEIGHT_NB    = 3,
    parameter int WIDTH_NB     = 3,
    parameter int IMG_WIDTH    = 8,
    parameter int KER_WIDTH    = 16,
    parameter int MAC_PIPELINE = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load_req,
    input  logic [KER_WIDTH-1:0]           ker_data,
    input  logic                           ker_val,
    output logic                           ker_rdy,
    input  logic [HEIGHT_NB*IMG_WIDTH-1:0] img_data,
    input  logic                           img_val,
    output logic                           img_rdy,
    output logic [KER_WIDTH-1:0]           cfg_ker,
    output logic                           cfg_val,
    output logic [HEIGHT_NB*IMG_WIDTH-1:0] up_img,
    output logic                           up_val,
    input  logic                           result_val,
    output logic                           loaded,
    output logic                           busy,
    output logic                           err
);

    localparam int MAC_NB     = HEIGHT_NB * WIDTH_NB;
    localparam int PIPE_DEPTH = MAC_PIPELINE * WIDTH_NB;
    localparam int CNT_W      = (MAC_NB > 1) ? $clog2(MAC_NB) : 1;
    localparam int INF_W      = $clog2(PIPE_DEPTH + 1);

    localparam logic [CNT_W-1:0] LAST_COEF = CNT_W'(MAC_NB - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] coef_cnt;
    logic [INF_W-1:0] inflight;
    logic             ker_xfer;
    logic             img_xfer;
    logic             drained;

    assign ker_rdy  = (state == S_LOAD);
    assign img_rdy  = (state == S_RUN) & ~load_req;
    assign busy     = (state == S_LOAD) | (state == S_DRAIN);
    assign ker_xfer = ker_val & ker_rdy;
    assign img_xfer = img_val & img_rdy;
    // up_val still high means a column is entering the filter and its result is not yet counted out
    assign drained  = (inflight == '0) & ~up_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            coef_cnt <= '0;
            loaded   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_req)
                        state <= S_LOAD;
                end
                S_LOAD: begin
                    if (ker_xfer) begin
                        if (coef_cnt == LAST_COEF) begin
                            coef_cnt <= '0;
                            loaded   <= 1'b1;
                            state    <= S_RUN;
                        end else begin
                            coef_cnt <= coef_cnt + CNT_W'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (load_req) begin
                        loaded <= 1'b0;
                        state  <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drained)
                        state <= S_LOAD;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // In-flight accounting; a result with nothing outstanding is flagged instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
            err      <= 1'b0;
        end else if (img_xfer && !result_val) begin
            inflight <= inflight + INF_W'(1);
        end else if (result_val && !img_xfer) begin
            if (inflight == '0)
                err <= 1'b1;
            else
                inflight <= inflight - INF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_ker <= '0;
            cfg_val <= 1'b0;
            up_img  <= '0;
            up_val  <= 1'b0;
        end else begin
            cfg_val <= ker_xfer;
            up_val  <= img_xfer;
            if (ker_xfer)
                cfg_ker <= ker_data;
            if (img_xfer)
                up_img <= img_data;
        end
    end

endmodule

// File: tb/tb_filter_ctrl.sv
// Bench for filter_ctrl: fixed vector table, directed corner sequences, and random traffic
// compared each cycle against a transaction-level reference with a fixed-latency filter stand-in.
module tb_filter_ctrl;

    localparam int H      = 3;
    localparam int W      = 3;
    localparam int IW     = 8;
    localparam int KW     = 16;
    localparam int MP     = 5;
    localparam int MAC_NB = H * W;
    localparam int PD     = MP * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_req = 1'b0;
    logic [KW-1:0] ker_data = '0;
    logic          ker_val = 1'b0;
    logic          ker_rdy;
    logic [H*IW-1:0] img_data = '0;
    logic          img_val = 1'b0;
    logic          img_rdy;
    logic [KW-1:0] cfg_ker;
    logic          cfg_val;
    logic [H*IW-1:0] up_img;
    logic          up_val;
    logic          result_val = 1'b0;
    logic          loaded;
    logic          busy;
    logic          err;

    filter_ctrl #(
        .HEIGHT_NB(H), .WIDTH_NB(W), .IMG_WIDTH(IW), .KER_WIDTH(KW), .MAC_PIPELINE(MP)
    ) dut (
        .clk(clk), .rst(rst), .load_req(load_req),
        .ker_data(ker_data), .ker_val(ker_val), .ker_rdy(ker_rdy),
        .img_data(img_data), .img_val(img_val), .img_rdy(img_rdy),
        .cfg_ker(cfg_ker), .cfg_val(cfg_val), .up_img(up_img), .up_val(up_val),
        .result_val(result_val), .loaded(loaded), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Stimulus for the next cycle
    bit            d_rst, d_ld, d_kv, d_iv, d_spur;
    logic [KW-1:0] d_kd;
    logic [H*IW-1:0] d_id;
    bit            use_filter;

    // Reference: what the sequencer should be doing, in transaction terms
    typedef enum int {P_IDLE, P_LOAD, P_RUN, P_DRAIN} phase_t;
    phase_t        m_phase = P_IDLE;
    bit            m_valid = 0;
    int            m_coefs_taken;
    int            m_outstanding;
    bit            m_loaded, m_err, m_cfg_val, m_up_val;
    logic [KW-1:0] m_cfg_ker;
    logic [H*IW-1:0] m_up_img;
    int            due[$];
    int            cyc = 0;
    int            last_res_cyc = -1;
    bit            c_ker_rdy, c_img_rdy;

    task automatic idle_inputs();
        d_rst = 0; d_ld = 0; d_kv = 0; d_iv = 0; d_spur = 0;
        d_kd = '0; d_id = '0;
    endtask

    task automatic model_update(input bit res);
        bit accept_k, accept_i, empty;
        accept_k = d_kv && (m_phase == P_LOAD);
        accept_i = d_iv && (m_phase == P_RUN) && !d_ld;
        empty    = (m_outstanding == 0) && !m_up_val;
        if (d_rst) begin
            m_phase = P_IDLE; m_coefs_taken = 0; m_outstanding = 0;
            m_loaded = 0; m_err = 0; m_cfg_val = 0; m_up_val = 0;
            m_cfg_ker = '0; m_up_img = '0;
            due.delete();
            m_valid = 1;
        end else begin
            if (m_phase == P_IDLE && d_ld) m_phase = P_LOAD;
            else if (m_phase == P_LOAD && accept_k) begin
                m_coefs_taken++;
                if (m_coefs_taken == MAC_NB) begin
                    m_coefs_taken = 0; m_loaded = 1; m_phase = P_RUN;
                end
            end else if (m_phase == P_RUN && d_ld) begin
                m_loaded = 0; m_phase = P_DRAIN;
            end else if (m_phase == P_DRAIN && empty) m_phase = P_LOAD;
            m_outstanding = m_outstanding + (accept_i ? 1 : 0) - (res ? 1 : 0);
            if (m_outstanding < 0) begin
                m_outstanding = 0; m_err = 1;
            end
            m_cfg_val = accept_k;
            if (accept_k) m_cfg_ker = d_kd;
            m_up_val = accept_i;
            if (accept_i) m_up_img = d_id;
            if (accept_i && use_filter) due.push_back(cyc + PD);
        end
        cyc++;
    endtask

    task automatic step_a();
        bit res;
        @(negedge clk);
        res = d_spur;
        if (use_filter && due.size() > 0 && due[0] == cyc) begin
            res = 1;
            void'(due.pop_front());
        end
        rst = d_rst; load_req = d_ld; ker_val = d_kv; ker_data = d_kd;
        img_val = d_iv; img_data = d_id; result_val = res;
        if (res) last_res_cyc = cyc;
        #1;
        c_ker_rdy = ker_rdy;
        c_img_rdy = img_rdy;
        if (m_valid) begin
            chk("ker_rdy", ker_rdy, m_phase == P_LOAD);
            chk("img_rdy", img_rdy, (m_phase == P_RUN) && !d_ld);
        end
        model_update(res);
    endtask

    task automatic step_b();
        @(posedge clk);
        #1;
        if (m_valid) begin
            chk("cfg_val", cfg_val, m_cfg_val);
            chk("cfg_ker", cfg_ker, m_cfg_ker);
            chk("up_val",  up_val,  m_up_val);
            chk("up_img",  up_img,  m_up_img);
            chk("loaded",  loaded,  m_loaded);
            chk("busy",    busy,    (m_phase == P_LOAD) || (m_phase == P_DRAIN));
            chk("err",     err,     m_err);
        end
    endtask

    task automatic step();
        step_a();
        step_b();
    endtask

    task automatic do_reset();
        idle_inputs(); d_rst = 1; step(); d_rst = 0;
    endtask

    task automatic load_kernel(input int base);
        idle_inputs(); d_ld = 1; step();
        for (int k = 0; k < MAC_NB; k++) begin
            idle_inputs(); d_kv = 1; d_kd = KW'(base + k); step();
        end
        idle_inputs();
    endtask

    task automatic wait_ker_rdy(input string nm, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < 200 && at_cyc < 0; i++) begin
            idle_inputs(); step_a();
            if (c_ker_rdy) at_cyc = cyc - 1;
            step_b();
        end
        if (at_cyc < 0) chk({nm, "_timeout"}, 1, 0);
    endtask

    typedef struct {
        bit ld; bit kv; logic [KW-1:0] kd; bit iv; logic [H*IW-1:0] id; bit rv;
        bit e_krdy; bit e_irdy; bit e_cval; logic [KW-1:0] e_cker;
        bit e_uval; logic [H*IW-1:0] e_uimg; bit e_loaded; bit e_busy;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int rdy_cyc, first_cfg, pulses, last_old_res;
        bit tenth_rdy;

        tbl[0] = '{1, 1, 16'h55, 0, 24'h0, 0,  0, 0, 0, 16'h0, 0, 24'h0, 0, 1};
        for (int k = 1; k <= MAC_NB; k++)
            tbl[k] = '{0, 1, KW'(k), 0, 24'h0, 0,  1, 0, 1, KW'(k), 0, 24'h0, k == MAC_NB, k != MAC_NB};
        tbl[10] = '{0, 1, 16'h77, 0, 24'h0, 0,  0, 1, 0, 16'h9, 0, 24'h0, 1, 0};
        tbl[11] = '{0, 0, 16'h0, 1, 24'h030201, 0,  0, 1, 0, 16'h9, 1, 24'h030201, 1, 0};
        tbl[12] = '{1, 0, 16'h0, 1, 24'h0A0B0C, 0,  0, 0, 0, 16'h9, 0, 24'h030201, 0, 1};
        tbl[13] = '{0, 0, 16'h0, 0, 24'h0, 1,  0, 0, 0, 16'h9, 0, 24'h030201, 0, 1};
        tbl[14] = '{0, 0, 16'h0, 0, 24'h0, 0,  0, 0, 0, 16'h9, 0, 24'h030201, 0, 1};
        tbl[15] = '{0, 1, 16'hAA, 0, 24'h0, 0,  1, 0, 1, 16'hAA, 0, 24'h030201, 0, 1};

        use_filter = 0;
        do_reset();
        chk("rst_cfg_val", cfg_val, 0);
        chk("rst_loaded", loaded, 0);
        chk("rst_busy", busy, 0);
        for (int i = 0; i < 16; i++) begin
            idle_inputs();
            d_ld = tbl[i].ld; d_kv = tbl[i].kv; d_kd = tbl[i].kd;
            d_iv = tbl[i].iv; d_id = tbl[i].id; d_spur = tbl[i].rv;
            step_a();
            chk($sformatf("tbl%0d_ker_rdy", i), c_ker_rdy, tbl[i].e_krdy);
            chk($sformatf("tbl%0d_img_rdy", i), c_img_rdy, tbl[i].e_irdy);
            step_b();
            chk($sformatf("tbl%0d_cfg_val", i), cfg_val, tbl[i].e_cval);
            chk($sformatf("tbl%0d_cfg_ker", i), cfg_ker, tbl[i].e_cker);
            chk($sformatf("tbl%0d_up_val", i), up_val, tbl[i].e_uval);
            chk($sformatf("tbl%0d_up_img", i), up_img, tbl[i].e_uimg);
            chk($sformatf("tbl%0d_loaded", i), loaded, tbl[i].e_loaded);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
        end

        // Streaming, then reload with a full pipeline of results still pending
        use_filter = 1;
        do_reset();
        load_kernel(1);
        for (int i = 0; i < 20; i++) begin
            idle_inputs(); d_iv = 1; d_id = H*IW'($urandom); step_a();
            chk("stream_img_rdy", c_img_rdy, 1);
            step_b();
        end
        for (int i = 0; i < PD + 5; i++) begin idle_inputs(); step(); end
        for (int i = 0; i < PD; i++) begin
            idle_inputs(); d_iv = 1; d_id = H*IW'($urandom); step();
        end
        idle_inputs(); d_ld = 1; d_iv = 1; step_a();
        chk("reload_img_rdy", c_img_rdy, 0);
        step_b();
        chk("drain_busy", busy, 1);
        wait_ker_rdy("drain", rdy_cyc);
        last_old_res = last_res_cyc;
        chk("drain_release", rdy_cyc, last_old_res + 2);
        first_cfg = -1;
        for (int k = 0; k < MAC_NB; k++) begin
            idle_inputs(); d_kv = 1; d_kd = KW'(16'h100 + k); step();
            if (cfg_val && first_cfg < 0) first_cfg = cyc - 1;
        end
        chk("cfg_after_results", first_cfg > last_old_res, 1);
        chk("reload_loaded", loaded, 1);

        // Gappy coefficient stream; the tenth offer lands in RUN
        do_reset();
        idle_inputs(); d_ld = 1; step();
        pulses = 0; tenth_rdy = 1;
        for (int i = 0; i < 2 * (MAC_NB + 1); i++) begin
            idle_inputs(); d_kv = (i % 2 == 0); d_kd = KW'($urandom); step_a();
            if (i == 2 * MAC_NB) tenth_rdy = c_ker_rdy;
            step_b();
            if (cfg_val) pulses++;
        end
        chk("gappy_pulses", pulses, MAC_NB);
        chk("tenth_not_taken", tenth_rdy, 0);

        // Reset in the middle of a load
        do_reset();
        idle_inputs(); d_ld = 1; step();
        for (int k = 0; k < 4; k++) begin idle_inputs(); d_kv = 1; d_kd = KW'(k + 1); step(); end
        do_reset();
        chk("midrst_cfg_ker", cfg_ker, 0);
        chk("midrst_cfg_val", cfg_val, 0);
        chk("midrst_busy", busy, 0);
        idle_inputs(); d_kv = 1; d_kd = 16'h33; step_a();
        chk("midrst_idle_ker_rdy", c_ker_rdy, 0);
        step_b();
        load_kernel(40);
        chk("midrst_reload_loaded", loaded, 1);
        chk("midrst_reload_busy", busy, 0);

        // Spurious result with nothing outstanding
        do_reset();
        idle_inputs(); d_spur = 1; step();
        chk("spur_err", err, 1);
        for (int i = 0; i < 5; i++) begin idle_inputs(); step(); end
        chk("spur_err_sticky", err, 1);
        load_kernel(7);
        idle_inputs(); d_iv = 1; d_id = 24'h123456; step();
        idle_inputs(); d_ld = 1; step();
        wait_ker_rdy("spur_drain", rdy_cyc);
        chk("spur_drain_release", rdy_cyc, last_res_cyc + 2);

        // Random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            idle_inputs();
            d_ld = ($urandom_range(0, 15) == 0);
            d_kv = $urandom_range(0, 1);
            d_kd = KW'($urandom);
            d_iv = ($urandom_range(0, 9) < 7);
            d_id = H*IW'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
